// File: rtl/banco_wr_arbiter.sv
// banco_wr_arbiter: two-requester write-back arbiter for the register bank write port with hazard mask
module banco_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ADDR_WIDTH-1:0]      a_end,
  input  logic [DATA_WIDTH-1:0]      a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_WIDTH-1:0]      b_end,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic                       wren,
  output logic [ADDR_WIDTH-1:0]      end_reg_d,
  output logic [DATA_WIDTH-1:0]      data_in,
  output logic [(1<<ADDR_WIDTH)-1:0] pend_mask
);
  logic                  hold_a_valid, hold_b_valid, older_is_b, tied, rr;
  logic [ADDR_WIDTH-1:0] hold_a_end, hold_b_end;
  logic [DATA_WIDTH-1:0] hold_a_data, hold_b_data;
  logic                  cap_a, cap_b, tie, grant_a, grant_b;
  assign a_ready = ~hold_a_valid;
  assign b_ready = ~hold_b_valid;
  // writes to $zero complete the handshake but never enter a hold
  assign cap_a   = a_valid & a_ready & (a_end != '0);
  assign cap_b   = b_valid & b_ready & (b_end != '0);
  assign tie     = hold_a_valid & hold_b_valid & tied;
  assign grant_a = hold_a_valid & (~hold_b_valid | (tie ? ~rr : ~older_is_b));
  assign grant_b = hold_b_valid & ~grant_a;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_a_valid <= 1'b0;
      hold_b_valid <= 1'b0;
      hold_a_end   <= '0;
      hold_b_end   <= '0;
      hold_a_data  <= '0;
      hold_b_data  <= '0;
      older_is_b   <= 1'b0;
      tied         <= 1'b0;
      rr           <= 1'b0;
      wren         <= 1'b0;
      end_reg_d    <= '0;
      data_in      <= '0;
    end else begin
      hold_a_valid <= cap_a | (hold_a_valid & ~grant_a);
      hold_b_valid <= cap_b | (hold_b_valid & ~grant_b);
      if (cap_a) begin
        hold_a_end  <= a_end;
        hold_a_data <= a_data;
      end
      if (cap_b) begin
        hold_b_end  <= b_end;
        hold_b_data <= b_data;
      end
      // a lone capture makes the other side (if still held) the older entry
      if (cap_a & cap_b) tied <= 1'b1;
      else if (cap_a | cap_b) begin
        tied       <= 1'b0;
        older_is_b <= cap_a;
      end
      if (tie) rr <= ~rr;
      wren <= grant_a | grant_b;
      if (grant_a | grant_b) begin
        end_reg_d <= grant_a ? hold_a_end : hold_b_end;
        data_in   <= grant_a ? hold_a_data : hold_b_data;
      end
    end
  end
  always_comb begin
    pend_mask = '0;
    if (hold_a_valid) pend_mask[hold_a_end] = 1'b1;
    if (hold_b_valid) pend_mask[hold_b_end] = 1'b1;
    if (wren) pend_mask[end_reg_d] = 1'b1;
  end
endmodule

// File: doc/banco_wr_arbiter.md
Name: banco_wr_arbiter

Overview:
- Shares the single write port of the register bank (wren / end_reg_d / data_in) between two write-back requesters: A = ALU write-back, B = load/IO unit.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Writes issue in arrival order; same-cycle ties are broken round-robin.
- Exports a pending-write mask so the decode stage can stall on read-after-write hazards.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width; register count = 2**ADDR_WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A offers a write.
- a_ready  out  1  A holding buffer empty; transfer on a_valid & a_ready.
- a_end  in  ADDR_WIDTH  A destination register.
- a_data  in  DATA_WIDTH  A write data.
- b_valid  in  1  requester B offers a write.
- b_ready  out  1  B holding buffer empty.
- b_end  in  ADDR_WIDTH  B destination register.
- b_data  in  DATA_WIDTH  B write data.
- wren  out  1  write enable to register bank (registered).
- end_reg_d  out  ADDR_WIDTH  write address to register bank (registered).
- data_in  out  DATA_WIDTH  write data to register bank (registered).
- pend_mask  out  2**ADDR_WIDTH  bit r = 1 while a write to register r is held or on the port.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Both holds empty; a_ready = b_ready = 1.
  - wren = 0, end_reg_d = 0, data_in = 0, pend_mask = 0.
  - Round-robin pointer = A; age flag cleared.
  - Reset mid-operation discards held writes; no partial write is issued.
- Accept: on a rising edge with x_valid & x_ready, x_end and x_data are captured into hold_x.
  - x_ready = ~hold_x_valid, a pure register with no combinational path from valid.
  - If x_end == 0, the transfer is accepted but discarded: the hold stays empty and no write is issued ($zero is never written).
- Age tracking:
  - A 1-bit flag older_is_b is set when exactly one hold was already valid at the time the other captured.
  - If both capture on the same edge, the entries are "tied".
- Grant: evaluated each edge on the current hold state. Priority order:
  1. If only one hold is valid, grant it.
  2. If both are valid and not tied, grant the older.
  3. If tied, grant the side named by the rr pointer; the pointer then toggles to the other side.
  - The pointer changes only on tie grants.
- Issue: the granted entry loads the output registers (wren = 1, end_reg_d, data_in) on the same edge its hold is cleared.
  - When nothing is granted, wren = 0; end_reg_d and data_in hold their previous values.
- Latency: accept at edge N, output registers load at edge N+1, register bank writes at edge N+2.
  - Hold freed at N+1, so x_ready is high again in the cycle after N+1.
- A new accept into a hold and that hold's grant can never occur on the same edge, since a hold is not ready while valid.
- Throughput: one write per cycle when A and B alternate; a single requester gets one write per 2 cycles.
- Same-register writes from A and B always complete in arrival order; ties complete A-then-B on the first tie after reset.
- pend_mask:
  - Combinational OR of decode(hold_a end) if valid, decode(hold_b end) if valid, and decode(end_reg_d) if wren.
  - Bit 0 is always 0.
- Only one wren per cycle; the arbiter never drops an accepted nonzero write.

Test Plan:
- Single A write:
  - Stimulus: a_valid = 1, a_end = 5, a_data = 0xDEADBEEF at edge 1.
  - Response: wren = 1, end_reg_d = 5, data_in = 0xDEADBEEF after edge 2.
  - pend_mask = 0x20 from after edge 1 through the cycle after edge 2; a_ready low for exactly one cycle.
- Tie fairness:
  - Stimulus: A (r3, 0x11) and B (r4, 0x22) on the same edge, twice in succession.
  - Response: first pair issues A then B; second pair issues B then A (pointer toggled).
- Arrival order:
  - Stimulus: B (r7, 0xB) at edge 1, A (r7, 0xA) at edge 2.
  - Response: B issues before A; r7 final value 0xA.
- $zero drop:
  - Stimulus: a_end = 0, a_data = 0xFFFFFFFF accepted.
  - Response: wren never asserted; pend_mask stays 0; a_ready stays 1.
- Back-to-back stream:
  - Stimulus: A and B hold valid continuously with distinct addresses for 20 cycles.
  - Response: wren = 1 every cycle after fill; grants alternate; no accepted write lost (scoreboard count 20).
- Async reset:
  - Stimulus: assert reset_n = 0 mid-cycle with both holds full and wren = 1.
  - Response: wren, pend_mask, and both holds clear immediately without waiting for a clock edge; the next accept after release issues normally.
